syscall_seq: RTL and testbench

Sequencer for the pipeline's syscall path. On a decoded syscall it freezes fetch/decode and bubbles execute, then waits for in-flight instructions to retire. It reads $v0/$a0 and carries out the service: print int as hex, print char, print NUL-terminated string from data memory, or exit. It sits beside the hazard unit; its stall output is ORed into StallF/StallD/FlushE, and it owns a read port into data memory plus a byte-wide console handshake.

---
 rtl/syscall_seq.sv | 203 ++++++++++++++++++++
 tb/tb_syscall_seq.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/syscall_seq.sv
// syscall_seq: sequences one syscall at a time beside the hazard unit.
// When a syscall reaches decode, fetch and decode are frozen and execute is
// bubbled. Once older instructions have drained, the block carries out the
// service: print hex, print char, print string from data memory, or exit.
module syscall_seq #(
  parameter int DRAIN_CYCLES = 3,
  parameter int MAX_STR      = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_d,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        done,
  output logic        halt,
  output logic        err
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int CW = $clog2(MAX_STR + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DRAIN, S_DECODE, S_HEX, S_CHAR, S_STR_REQ,
    S_STR_WAIT, S_STR_OUT, S_ERR, S_DONE, S_HALT
  } state_t;

  state_t         r_state;
  logic [DW-1:0]  r_drain;
  logic [31:0]    r_arg;
  logic [2:0]     r_nib;
  logic [31:0]    r_ptr;
  logic [CW-1:0]  r_count;
  logic           r_mem_rd_en;
  logic [31:0]    r_mem_addr;
  logic           r_out_valid;
  logic [7:0]     r_out_data;
  logic           r_done;
  logic           r_halt;
  logic           r_err;

  logic           w_hs;
  logic [2:0]     w_nib_dec;
  logic [31:0]    w_ptr_inc;
  logic [CW-1:0]  w_count_inc;
  logic [7:0]     w_byte;

  // Lower-case ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign w_hs        = r_out_valid & out_ready;
  assign w_nib_dec   = r_nib - 3'd1;
  assign w_ptr_inc   = r_ptr + 32'd1;
  assign w_count_inc = r_count + CW'(1);

  // Big-endian byte lane selected by the low pointer bits.
  always_comb begin
    w_byte = 8'h00;
    case (r_ptr[1:0])
      2'd0:    w_byte = mem_rdata[31:24];
      2'd1:    w_byte = mem_rdata[23:16];
      2'd2:    w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
  end

  // Sequencer FSM with registered outputs; reset aborts any service at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drain     <= '0;
      r_arg       <= '0;
      r_nib       <= '0;
      r_ptr       <= '0;
      r_count     <= '0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_halt      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_rd_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (syscall_d) begin
            r_state <= S_DRAIN;
            r_drain <= DW'(DRAIN_CYCLES - 1);
          end
        end
        S_DRAIN: begin
          if (r_drain == '0) r_state <= S_DECODE;
          else               r_drain <= r_drain - 1'b1;
        end
        S_DECODE: begin
          r_arg <= a0;
          case (v0)
            32'd1: begin
              r_state     <= S_HEX;
              r_nib       <= 3'd7;
              r_out_valid <= 1'b1;
              r_out_data  <= hex_ascii(a0[31:28]);
            end
            32'd11: begin
              r_state     <= S_CHAR;
              r_out_valid <= 1'b1;
              r_out_data  <= a0[7:0];
            end
            32'd4: begin
              r_state     <= S_STR_REQ;
              r_ptr       <= a0;
              r_count     <= '0;
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= {a0[31:2], 2'b00};
            end
            32'd10: begin
              r_state <= S_HALT;
              r_halt  <= 1'b1;
            end
            default: begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          endcase
        end
        S_HEX: begin
          if (w_hs) begin
            if (r_nib == 3'd0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_nib      <= w_nib_dec;
              r_out_data <= hex_ascii(r_arg[{w_nib_dec, 2'b00} +: 4]);
            end
          end
        end
        S_CHAR: begin
          if (w_hs) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
          end
        end
        S_STR_REQ: r_state <= S_STR_WAIT;
        S_STR_WAIT: begin
          if (w_byte == 8'h00) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state     <= S_STR_OUT;
            r_out_valid <= 1'b1;
            r_out_data  <= w_byte;
          end
        end
        S_STR_OUT: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_ptr       <= w_ptr_inc;
            r_count     <= w_count_inc;
            if (w_count_inc == CW'(MAX_STR)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state     <= S_STR_REQ;
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= {w_ptr_inc[31:2], 2'b00};
            end
          end
        end
        S_ERR: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Stall is immediate on a decoded syscall, held until retire, and forever after exit.
  assign stall     = (r_state == S_IDLE) ? syscall_d : (r_state != S_DONE);
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;
  assign halt      = r_halt;
  assign err       = r_err;

endmodule

// File: tb/tb_syscall_seq.sv
// Bench for syscall_seq: directed scenarios plus randomized syscalls,
// checked against a transaction-level model of each service.
module tb_syscall_seq;

  localparam int DRAIN = 3;
  localparam int MAXS  = 4;

  logic        clk = 1'b0;
  logic        reset, syscall_d, stall, mem_rd_en, out_valid, out_ready;
  logic        done, halt, err;
  logic [31:0] v0, a0, mem_addr, mem_rdata;
  logic [7:0]  out_data;

  always #5 clk = ~clk;

  syscall_seq #(.DRAIN_CYCLES(DRAIN), .MAX_STR(MAXS)) dut (
    .clk(clk), .reset(reset), .syscall_d(syscall_d), .v0(v0), .a0(a0),
    .stall(stall), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .done(done), .halt(halt), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sparse data memory; absent words read as zero.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] addr);
    logic [31:0] w;
    int sh;
    w  = mem_word({addr[31:2], 2'b00});
    sh = 24 - 8 * int'(addr[1:0]);
    return w[sh +: 8];
  endfunction

  task automatic set_byte(input logic [31:0] addr, input logic [7:0] b);
    logic [31:0] w;
    int sh;
    w  = {addr[31:2], 2'b00};
    sh = 24 - 8 * int'(addr[1:0]);
    if (!mem.exists(w)) mem[w] = $urandom;
    mem[w] = (mem[w] & ~(32'hFF << sh)) | ({24'h0, b} << sh);
  endtask

  // Read port: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem_word(mem_addr) : $urandom;

  // Console readiness pattern.
  int rdy_mode = 0;
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: accepted bytes, read addresses, pulses, handshake stability.
  logic [7:0]  got_b[$];
  logic [31:0] got_a[$];
  int n_err_p = 0, n_done_p = 0, n_unstable = 0;
  logic pv_wait = 1'b0;
  logic [7:0] pv_data = 8'h0;
  always @(negedge clk) begin
    if (pv_wait && (!out_valid || out_data !== pv_data)) n_unstable++;
    pv_wait = out_valid && !out_ready && !reset;
    pv_data = out_data;
    if (out_valid && out_ready) got_b.push_back(out_data);
    if (mem_rd_en) got_a.push_back(mem_addr);
    if (err) n_err_p++;
    if (done) n_done_p++;
  end

  // Expected results of one syscall.
  logic [7:0]  exp_b[$];
  logic [31:0] exp_a[$];
  int exp_err, exp_done;

  task automatic model(input logic [31:0] code, input logic [31:0] arg);
    logic [31:0] p;
    logic [7:0]  b;
    string s;
    exp_b.delete();
    exp_a.delete();
    exp_err  = 0;
    exp_done = 1;
    if (code == 32'd1) begin
      s = $sformatf("%08h", arg);
      for (int i = 0; i < 8; i++) exp_b.push_back(s[i]);
    end else if (code == 32'd11) begin
      exp_b.push_back(arg[7:0]);
    end else if (code == 32'd4) begin
      p = arg;
      while (1) begin
        exp_a.push_back({p[31:2], 2'b00});
        b = mem_byte(p);
        if (b == 8'h00) break;
        exp_b.push_back(b);
        p = p + 32'd1;
        if (exp_b.size() == MAXS) begin
          exp_err = 1;
          break;
        end
      end
    end else if (code == 32'd10) begin
      exp_done = 0;
    end else begin
      exp_err = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    syscall_d = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {stall, mem_rd_en, mem_addr, out_valid, out_data, done, halt, err}, 64'h0);
  endtask

  task automatic run_sc(input logic [31:0] code, input logic [31:0] arg,
                        input int mode, input bit chk_lat);
    int bb, ba, be, bd, k, stall_bad, lat;
    bit fin;
    model(code, arg);
    bb = got_b.size(); ba = got_a.size(); be = n_err_p; bd = n_done_p;
    rdy_mode = mode;
    @(posedge clk); #2;
    v0 = code; a0 = arg; syscall_d = 1'b1;
    @(negedge clk);
    chk("stall_on_syscall", stall, 1);
    k = 0; stall_bad = 0; lat = 0; fin = 0;
    while (!fin && k < 3000) begin
      @(negedge clk);
      k++;
      if (done) begin
        fin = 1;
        lat = k;
        if (stall) stall_bad++;
      end else if (code == 32'd10 && halt) begin
        fin = 1;
      end else if (!stall) begin
        stall_bad++;
      end
    end
    chk("finished", fin, 1);
    if (code != 32'd10) begin
      @(posedge clk); #2;
      syscall_d = 1'b0;
    end
    @(negedge clk);
    chk("stall_held", stall_bad, 0);
    chk("done_pulses", n_done_p - bd, exp_done);
    chk("err_pulses", n_err_p - be, exp_err);
    chk("byte_count", got_b.size() - bb, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++)
      if (bb + i < got_b.size()) chk("byte", got_b[bb + i], exp_b[i]);
    chk("read_count", got_a.size() - ba, exp_a.size());
    for (int i = 0; i < exp_a.size(); i++)
      if (ba + i < got_a.size()) chk("read_addr", got_a[ba + i], exp_a[i]);
    chk("out_stable", n_unstable, 0);
    if (chk_lat) chk("char_latency", lat, DRAIN + 3);
  endtask

  initial begin
    logic [31:0] code, base;
    int len, bb, k, bad;
    reset = 1'b1; syscall_d = 1'b0; v0 = '0; a0 = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Print char, console always ready.
    run_sc(32'd11, 32'h41, 0, 1);
    // Print int with a stalling console.
    run_sc(32'd1, 32'h00C0FFEE, 1, 0);
    // Print string starting mid-word.
    mem.delete();
    mem[32'h100] = 32'h48690000;
    run_sc(32'd4, 32'h101, 2, 0);
    // String longer than the overrun limit.
    mem.delete();
    for (int i = 0; i < 10; i++) set_byte(32'h300 + i, 8'h41 + 8'(i));
    set_byte(32'h30A, 8'h00);
    run_sc(32'd4, 32'h300, 2, 0);
    // Unknown service code.
    run_sc(32'd7, 32'h1234, 0, 0);

    // Reset in the middle of a string after two bytes.
    mem.delete();
    set_byte(32'h200, 8'h61); set_byte(32'h201, 8'h62);
    set_byte(32'h202, 8'h63); set_byte(32'h203, 8'h00);
    rdy_mode = 0;
    bb = got_b.size();
    @(posedge clk); #2;
    v0 = 32'd4; a0 = 32'h200; syscall_d = 1'b1;
    k = 0;
    while (got_b.size() < bb + 2 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk("midreset_reached", k < 200, 1);
    reset = 1'b1; syscall_d = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_outputs",
        {stall, mem_rd_en, mem_addr, out_valid, out_data, done, halt, err}, 64'h0);
    repeat (5) @(negedge clk);
    chk("midreset_no_more_bytes", got_b.size() - bb, 2);
    run_sc(32'd11, 32'h5A, 0, 1);

    // Randomized syscalls.
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 4))
        0: code = 32'd1;
        1: code = 32'd11;
        2, 3: code = 32'd4;
        default: begin
          code = $urandom;
          if (code == 32'd1 || code == 32'd4 || code == 32'd10 || code == 32'd11)
            code = 32'd7;
        end
      endcase
      base = $urandom;
      if (code == 32'd4) begin
        mem.delete();
        if ($urandom_range(0, 3) == 0) base = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        len = $urandom_range(0, 6);
        for (int j = 0; j < len; j++) set_byte(base + 32'(j), 8'($urandom_range(1, 255)));
        set_byte(base + 32'(len), 8'h00);
      end
      run_sc(code, base, $urandom_range(0, 2), 0);
    end

    // Exit: halt sticks, stall holds, further syscalls ignored.
    run_sc(32'd10, 32'h0, 0, 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      syscall_d = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!halt || !stall || done || out_valid || err) bad++;
    end
    chk("halt_sticky", bad, 0);
    do_reset();
    chk("halt_cleared", halt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
